// File: rtl/image_downscale_stream.sv
// Streaming integer-factor image decimator with valid/ready on both sides.
// Optional macro BOX_AVG_EN: average each DEC_HOR-pixel group instead of picking its first pixel.
module image_downscale_stream #(
  parameter int ROWS    = 484,
  parameter int COLS    = 494,
  parameter int DEC_VER = 2,
  parameter int DEC_HOR = 2,
  parameter int DW      = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_eol,
  output logic          m_eof,
  output logic          frame_done
);

  localparam int OUT_ROWS = ROWS / DEC_VER;
  localparam int OUT_COLS = COLS / DEC_HOR;
  localparam int RW  = $clog2(ROWS + 1);
  localparam int CW  = $clog2(COLS + 1);
  localparam int PRW = $clog2(DEC_VER + 1);
  localparam int PCW = $clog2(DEC_HOR + 1);

  localparam logic [RW-1:0]  ROW_LAST = RW'(ROWS - 1);
  localparam logic [RW-1:0]  ROW_LIM  = RW'(OUT_ROWS * DEC_VER);
  localparam logic [RW-1:0]  ROW_EOF  = RW'((OUT_ROWS - 1) * DEC_VER);
  localparam logic [CW-1:0]  COL_LAST = CW'(COLS - 1);
  localparam logic [CW-1:0]  COL_LIM  = CW'(OUT_COLS * DEC_HOR);
  localparam logic [PRW-1:0] PR_LAST  = PRW'(DEC_VER - 1);
  localparam logic [PCW-1:0] PC_LAST  = PCW'(DEC_HOR - 1);

`ifdef BOX_AVG_EN
  // The averaged pixel is emitted on the last column of its group.
  localparam logic [PCW-1:0] PC_PICK = PC_LAST;
  localparam logic [CW-1:0]  COL_EOL = CW'(OUT_COLS * DEC_HOR - 1);
`else
  localparam logic [PCW-1:0] PC_PICK = '0;
  localparam logic [CW-1:0]  COL_EOL = CW'((OUT_COLS - 1) * DEC_HOR);
`endif

  logic [RW-1:0]  row_reg;
  logic [CW-1:0]  col_reg;
  logic [PRW-1:0] ph_r_reg;
  logic [PCW-1:0] ph_c_reg;
  logic           accept;
  logic           last_col;
  logic           last_row;
  logic           keep;
  logic [DW-1:0]  pix_next;

  assign s_ready  = !m_valid || m_ready;
  assign accept   = s_valid && s_ready;
  assign last_col = (col_reg == COL_LAST);
  assign last_row = (row_reg == ROW_LAST);
  assign keep     = (ph_r_reg == '0) && (ph_c_reg == PC_PICK) &&
                    (row_reg < ROW_LIM) && (col_reg < COL_LIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      row_reg  <= '0;
      col_reg  <= '0;
      ph_r_reg <= '0;
      ph_c_reg <= '0;
    end else if (accept) begin
      if (last_col) begin
        col_reg  <= '0;
        ph_c_reg <= '0;
        if (last_row) begin
          row_reg  <= '0;
          ph_r_reg <= '0;
        end else begin
          row_reg  <= row_reg + 1'b1;
          ph_r_reg <= (ph_r_reg == PR_LAST) ? '0 : ph_r_reg + 1'b1;
        end
      end else begin
        col_reg  <= col_reg + 1'b1;
        ph_c_reg <= (ph_c_reg == PC_LAST) ? '0 : ph_c_reg + 1'b1;
      end
    end
  end

`ifdef BOX_AVG_EN
  localparam int AW = DW + $clog2(DEC_HOR) + 1;
  logic [AW-1:0] acc_reg;
  logic [AW-1:0] sum;

  // The first pixel of a group restarts the sum instead of adding to stale data.
  assign sum      = ((ph_c_reg == '0) ? '0 : acc_reg) + AW'(s_data);
  assign pix_next = DW'(sum / AW'(DEC_HOR));

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg <= '0;
    end else if (accept) begin
      acc_reg <= sum;
    end
  end
`else
  assign pix_next = s_data;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_eol      <= 1'b0;
      m_eof      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= accept && last_col && last_row;
      if (accept && keep) begin
        m_valid <= 1'b1;
        m_data  <= pix_next;
        m_eol   <= (col_reg == COL_EOL);
        m_eof   <= (col_reg == COL_EOL) && (row_reg == ROW_EOF);
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_image_downscale_stream.sv
// Scoreboard bench for image_downscale_stream: a 4x4 instance and a 5x5 instance, both decimating 2/2.
// Expected words {eol,eof,data} are queued at stimulus time and popped by an independent monitor.
module tb_image_downscale_stream;

  logic       clk;
  logic       rst;
  logic       s_valid_a, s_ready_a, m_valid_a, m_ready_a, m_eol_a, m_eof_a, frame_done_a;
  logic [7:0] s_data_a, m_data_a;
  logic       s_valid_b, s_ready_b, m_valid_b, m_ready_b, m_eol_b, m_eof_b, frame_done_b;
  logic [7:0] s_data_b, m_data_b;

  int errors = 0;
  int checks = 0;
  int fd_a   = 0;
  int fd_b   = 0;
  bit stall  = 0;
  int stall_cnt = 0;
  logic [9:0] qa[$];
  logic [9:0] qb[$];
  logic [7:0] t5 [16] = '{8'd10, 8'd20, 8'd30, 8'd41, 8'd50, 8'd51, 8'd52, 8'd53,
                          8'd1,  8'd2,  8'd3,  8'd4,  8'd60, 8'd61, 8'd62, 8'd63};

  image_downscale_stream #(.ROWS(4), .COLS(4), .DEC_VER(2), .DEC_HOR(2), .DW(8)) dut_a (
    .clk(clk), .rst(rst), .s_valid(s_valid_a), .s_ready(s_ready_a), .s_data(s_data_a),
    .m_valid(m_valid_a), .m_ready(m_ready_a), .m_data(m_data_a), .m_eol(m_eol_a),
    .m_eof(m_eof_a), .frame_done(frame_done_a));

  image_downscale_stream #(.ROWS(5), .COLS(5), .DEC_VER(2), .DEC_HOR(2), .DW(8)) dut_b (
    .clk(clk), .rst(rst), .s_valid(s_valid_b), .s_ready(s_ready_b), .s_data(s_data_b),
    .m_valid(m_valid_b), .m_ready(m_ready_b), .m_data(m_data_b), .m_eol(m_eol_b),
    .m_eof(m_eof_b), .frame_done(frame_done_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Downstream ready: always 1, or high one cycle in three while stalling.
  initial begin
    m_ready_a = 1'b1;
    m_ready_b = 1'b1;
    forever begin
      @(negedge clk);
      m_ready_a = stall ? (stall_cnt % 3 == 0) : 1'b1;
      stall_cnt++;
    end
  end

  // Monitor: samples mid-low-phase, pops on transfer, checks hold stability while stalled.
  initial begin
    bit         hold_a;
    logic [9:0] held_a, got, exp;
    hold_a = 0;
    held_a = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        hold_a = 0;
      end else begin
        got = {m_eol_a, m_eof_a, m_data_a};
        if (hold_a) begin
          chk("a_stall_valid", int'(m_valid_a), 1);
          chk("a_stall_stable", int'(got), int'(held_a));
        end
        if (m_valid_a) begin
          if (m_ready_a) begin
            hold_a = 0;
            if (qa.size() == 0) begin
              chk("a_unexpected_out", int'(got), -1);
            end else begin
              exp = qa.pop_front();
              chk("a_out", int'(got), int'(exp));
              $display("a out data=%0d eol=%0d eof=%0d", m_data_a, m_eol_a, m_eof_a);
            end
          end else begin
            hold_a = 1;
            held_a = got;
          end
        end else begin
          hold_a = 0;
        end
        if (m_valid_b && m_ready_b) begin
          got = {m_eol_b, m_eof_b, m_data_b};
          if (qb.size() == 0) begin
            chk("b_unexpected_out", int'(got), -1);
          end else begin
            exp = qb.pop_front();
            chk("b_out", int'(got), int'(exp));
            $display("b out data=%0d eol=%0d eof=%0d", m_data_b, m_eol_b, m_eof_b);
          end
        end
        if (frame_done_a) fd_a++;
        if (frame_done_b) fd_b++;
      end
    end
  end

  task automatic push_a(input int d, input bit eol, input bit eof);
    qa.push_back({eol, eof, 8'(d)});
  endtask

  task automatic push_b(input int d, input bit eol, input bit eof);
    qb.push_back({eol, eof, 8'(d)});
  endtask

  task automatic push_std_a();
    push_a(0, 0, 0);
    push_a(2, 1, 0);
    push_a(8, 0, 0);
    push_a(10, 1, 1);
  endtask

  // Holds s_valid with the pixel until a transfer; returns just after that edge.
  task automatic send(input bit to_b, input logic [7:0] d);
    int  n;
    bit  done;
    n = 0;
    done = 0;
    if (to_b) begin s_valid_b = 1'b1; s_data_b = d; end
    else      begin s_valid_a = 1'b1; s_data_a = d; end
    while (!done) begin
      @(negedge clk);
      #1;
      if (to_b ? s_ready_b : s_ready_a) done = 1;
      @(posedge clk);
      #1;
      n++;
      if (!done && n > 200) begin
        chk("send_timeout", n, 0);
        done = 1;
      end
    end
  endtask

  task automatic idle();
    s_valid_a = 1'b0;
    s_valid_b = 1'b0;
  endtask

  task automatic send_idx_a(input int n);
    for (int i = 0; i < n; i++) send(1'b0, 8'(i));
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 300) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk(name, qa.size() + qb.size(), 0);
    qa.delete();
    qb.delete();
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_m_valid"}, int'(m_valid_a), 0);
    chk({name, "_m_data"}, int'(m_data_a), 0);
    chk({name, "_m_eol"}, int'(m_eol_a), 0);
    chk({name, "_m_eof"}, int'(m_eof_a), 0);
    chk({name, "_frame_done"}, int'(frame_done_a), 0);
  endtask

  initial begin
    rst = 1'b1;
    s_valid_a = 1'b0; s_data_a = '0;
    s_valid_b = 1'b0; s_data_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // 4x4, free-flowing downstream
    fd_a = 0;
    push_std_a();
    send_idx_a(16);
    idle();
    drain("t1_drain");
    chk("t1_frame_done_count", fd_a, 1);

    // 4x4 with downstream ready one cycle in three
    fd_a = 0;
    stall = 1;
    push_std_a();
    send_idx_a(16);
    idle();
    drain("t2_drain");
    stall = 0;
    chk("t2_frame_done_count", fd_a, 1);

    // 5x5: last row and column are discarded
    fd_b = 0;
    push_b(0, 0, 0);
    push_b(2, 1, 0);
    push_b(10, 0, 0);
    push_b(12, 1, 1);
    for (int i = 0; i < 25; i++) send(1'b1, 8'(i));
    idle();
    drain("t3_drain");
    chk("t3_frame_done_count", fd_b, 1);

    // reset mid-frame after 6 pixels, then replay a full frame
    fd_a = 0;
    push_a(0, 0, 0);
    push_a(2, 1, 0);
    send_idx_a(6);
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("t4_reset");
    rst = 1'b0;
    push_std_a();
    send_idx_a(16);
    idle();
    drain("t4_drain");
    chk("t4_frame_done_count", fd_a, 1);

    // distinct pixel values: picked or averaged depending on build
`ifdef BOX_AVG_EN
    push_a(15, 0, 0);
    push_a(35, 1, 0);
    push_a(1, 0, 0);
    push_a(3, 1, 1);
`else
    push_a(10, 0, 0);
    push_a(30, 1, 0);
    push_a(1, 0, 0);
    push_a(3, 1, 1);
`endif
    for (int i = 0; i < 16; i++) send(1'b0, t5[i]);
    idle();
    drain("t5_drain");

    // two frames back-to-back, s_valid held high throughout
    fd_a = 0;
    push_std_a();
    push_std_a();
    for (int i = 0; i < 32; i++) send(1'b0, 8'(i % 16));
    idle();
    drain("t6_drain");
    chk("t6_frame_done_count", fd_a, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
